// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB boundary with a two-entry skid queue, write-back mux and retired-write counter.
// Define MEM_WB_FWD_EN to build the Execute-stage forwarding port; otherwise the fwd outputs are tied to 0.
module mem_wb_stage #(
    parameter int W    = 16,
    parameter int RIDX = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3*W+2:0]   i_in_data,
    input  logic [RIDX-1:0]  i_in_rdst,
    input  logic             i_flush,
    input  logic             i_wb_ready,
    output logic             o_wb_en,
    output logic [RIDX-1:0]  o_wb_addr,
    output logic [W-1:0]     o_wb_data,
    output logic [15:0]      o_retired,
    output logic             o_fwd_valid,
    output logic [RIDX-1:0]  o_fwd_addr,
    output logic [W-1:0]     o_fwd_data
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            r_state, w_next;
    logic              r_in_ready;
    logic [3*W+2:0]    r_h_data, r_s_data;
    logic [RIDX-1:0]   r_h_rdst, r_s_rdst;
    logic [15:0]       r_retired;
    logic              w_push, w_pop, w_load_h, w_load_s, w_shift, w_retire;

    // Source select: 01 mem, 10 Imm, 00/11 ALU.
    function automatic logic [W-1:0] sel(input logic [3*W+2:0] b);
        return (b[3*W+2:3*W+1] == 2'b01) ? b[W-1:0] :
               (b[3*W+2:3*W+1] == 2'b10) ? b[3*W-1:2*W] : b[2*W-1:W];
    endfunction

    assign w_push   = i_in_valid && r_in_ready;
    assign w_pop    = (r_state != EMPTY) && (i_wb_ready || !r_h_data[3*W]);
    assign w_retire = !i_flush && w_pop && r_h_data[3*W];

    always_comb begin
        w_next   = r_state;
        w_load_h = 1'b0;
        w_load_s = 1'b0;
        w_shift  = 1'b0;
        case (r_state)
            EMPTY: if (w_push) begin
                w_next   = ONE;
                w_load_h = 1'b1;
            end
            ONE: if (w_push && w_pop) begin
                w_load_h = 1'b1;
            end else if (w_push) begin
                w_next   = FULL;
                w_load_s = 1'b1;
            end else if (w_pop) begin
                w_next   = EMPTY;
            end
            FULL: if (w_pop) begin
                w_next  = ONE;
                w_shift = 1'b1;
            end
            default: w_next = EMPTY;
        endcase
        if (i_flush) w_next = EMPTY;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_h_data   <= '0;
            r_h_rdst   <= '0;
            r_s_data   <= '0;
            r_s_rdst   <= '0;
            r_retired  <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != FULL);
            if (w_load_h) begin
                r_h_data <= i_in_data;
                r_h_rdst <= i_in_rdst;
            end else if (w_shift) begin
                r_h_data <= r_s_data;
                r_h_rdst <= r_s_rdst;
            end
            if (w_load_s) begin
                r_s_data <= i_in_data;
                r_s_rdst <= i_in_rdst;
            end
            if (w_retire) r_retired <= r_retired + 16'd1;
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_wb_en    = (r_state != EMPTY) && r_h_data[3*W];
    assign o_wb_addr  = r_h_rdst;
    assign o_wb_data  = sel(r_h_data);
    assign o_retired  = r_retired;

`ifdef MEM_WB_FWD_EN
    // The skid entry is younger than the head, so it wins when both write.
    logic w_s_fwd, w_h_fwd;
    assign w_s_fwd     = (r_state == FULL) && r_s_data[3*W];
    assign w_h_fwd     = (r_state != EMPTY) && r_h_data[3*W];
    assign o_fwd_valid = w_s_fwd || w_h_fwd;
    assign o_fwd_addr  = w_s_fwd ? r_s_rdst : w_h_fwd ? r_h_rdst : '0;
    assign o_fwd_data  = w_s_fwd ? sel(r_s_data) : w_h_fwd ? sel(r_h_data) : '0;
`else
    assign o_fwd_valid = 1'b0;
    assign o_fwd_addr  = '0;
    assign o_fwd_data  = '0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed stimulus with a FIFO reference model and negedge scoreboard monitor.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        wb_ready = 1'b0;
    logic [50:0] in_data = '0;
    logic [2:0]  in_rdst = '0;
    logic        in_ready, wb_en, fwd_valid;
    logic [2:0]  wb_addr, fwd_addr;
    logic [15:0] wb_data, retired, fwd_data;

    mem_wb_stage #(.W(16), .RIDX(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_data(in_data), .i_in_rdst(in_rdst), .i_flush(flush), .i_wb_ready(wb_ready),
        .o_wb_en(wb_en), .o_wb_addr(wb_addr), .o_wb_data(wb_data), .o_retired(retired),
        .o_fwd_valid(fwd_valid), .o_fwd_addr(fwd_addr), .o_fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [2:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_ret = '0;
    bit          mon_en = 1'b0;

    function automatic ent_t model(input logic [50:0] b, input logic [2:0] r);
        ent_t e;
        e.rw = b[48];
        e.a  = r;
        case (b[50:49])
            2'b01:   e.d = b[15:0];
            2'b10:   e.d = b[47:32];
            default: e.d = b[31:16];
        endcase
        return e;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [50:0] d, input logic [2:0] r,
                         input logic wr, input logic f, output bit acc);
        in_valid = v;
        in_data  = d;
        in_rdst  = r;
        wb_ready = wr;
        flush    = f;
        @(negedge clk);
        acc = v && in_ready && !f;
        @(posedge clk);
        if (acc) q.push_back(model(d, r));
        #1;
    endtask

    task automatic idle(input logic wr);
        bit a;
        cycle(1'b0, '0, '0, wr, 1'b0, a);
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        q.delete();
        exp_ret  = '0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_wb_en", 32'(wb_en), 32'(0));
        chk("rst_wb_addr", 32'(wb_addr), 32'(0));
        chk("rst_wb_data", 32'(wb_data), 32'(0));
        chk("rst_retired", 32'(retired), 32'(0));
        chk("rst_fwd", 32'({fwd_valid, fwd_addr, fwd_data}), 32'(0));
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            ent_t        h;
            logic        fv;
            logic [2:0]  fa;
            logic [15:0] fd;
            fv = 1'b0;
            fa = '0;
            fd = '0;
`ifdef MEM_WB_FWD_EN
            foreach (q[i]) if (q[i].rw) begin
                fv = 1'b1;
                fa = q[i].a;
                fd = q[i].d;
            end
`endif
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("retired", 32'(retired), 32'(exp_ret));
            chk("fwd", 32'({fwd_valid, fwd_addr, fwd_data}), 32'({fv, fa, fd}));
            if (q.size() == 0) begin
                chk("wb_en_idle", 32'(wb_en), 32'(0));
            end else begin
                h = q[0];
                chk("wb_en", 32'(wb_en), 32'(h.rw));
                if (h.rw) begin
                    chk("wb_addr", 32'(wb_addr), 32'(h.a));
                    chk("wb_data", 32'(wb_data), 32'(h.d));
                end
                if (!flush && (wb_ready || !h.rw)) begin
                    void'(q.pop_front());
                    if (h.rw) exp_ret = exp_ret + 16'd1;
                end
            end
            if (flush) q.delete();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit          acc;
        logic [15:0] r0;
        @(posedge clk);
        #1;
        do_reset();

        // Basic write of the mem field.
        cycle(1'b1, {3'b011, 16'h1111, 16'h2222, 16'hBEEF}, 3'd5, 1'b1, 1'b0, acc);
        chk("t1_acc", 32'(acc), 32'(1));
        chk("t1_wb_en", 32'(wb_en), 32'(1));
        chk("t1_wb_addr", 32'(wb_addr), 32'(5));
        chk("t1_wb_data", 32'(wb_data), 32'(16'hBEEF));
        idle(1'b1);
        chk("t1_retired", 32'(retired), 32'(1));

        // Back-pressure: two accepted, third stalled until release.
        cycle(1'b1, {3'b001, 16'h0001, 16'hA001, 16'h0002}, 3'd1, 1'b0, 1'b0, acc);
        chk("t2_acc1", 32'(acc), 32'(1));
        cycle(1'b1, {3'b011, 16'h0003, 16'h0004, 16'hB002}, 3'd2, 1'b0, 1'b0, acc);
        chk("t2_acc2", 32'(acc), 32'(1));
        chk("t2_in_ready_low", 32'(in_ready), 32'(0));
        cycle(1'b1, {3'b101, 16'hC003, 16'h0005, 16'h0006}, 3'd3, 1'b0, 1'b0, acc);
        chk("t2_acc3_blocked", 32'(acc), 32'(0));
        for (int i = 0; i < 8 && !acc; i++)
            cycle(1'b1, {3'b101, 16'hC003, 16'h0005, 16'h0006}, 3'd3, 1'b1, 1'b0, acc);
        chk("t2_acc3_late", 32'(acc), 32'(1));
        repeat (4) idle(1'b1);
        chk("t2_drained", 32'(q.size()), 32'(0));

        // regWrite=0 pops silently.
        r0 = retired;
        cycle(1'b1, {3'b100, 16'h5555, 16'h6666, 16'h7777}, 3'd4, 1'b1, 1'b0, acc);
        chk("t3_wb_en", 32'(wb_en), 32'(0));
        repeat (2) idle(1'b1);
        chk("t3_retired", 32'(retired), 32'(r0));

        // Flush a full queue with a simultaneous push.
        cycle(1'b1, {3'b001, 16'h0, 16'h1234, 16'h0}, 3'd6, 1'b0, 1'b0, acc);
        cycle(1'b1, {3'b001, 16'h0, 16'h4321, 16'h0}, 3'd7, 1'b0, 1'b0, acc);
        cycle(1'b1, {3'b001, 16'h0, 16'h9999, 16'h0}, 3'd1, 1'b1, 1'b1, acc);
        chk("t4_wb_en", 32'(wb_en), 32'(0));
        chk("t4_in_ready", 32'(in_ready), 32'(1));
        chk("t4_retired", 32'(retired), 32'(r0));
        idle(1'b1);

        // Forwarding: H and S both write, S is youngest.
        cycle(1'b1, {3'b001, 16'h0000, 16'h0A0A, 16'h0000}, 3'd2, 1'b0, 1'b0, acc);
        cycle(1'b1, {3'b101, 16'h7777, 16'h0000, 16'h0000}, 3'd3, 1'b0, 1'b0, acc);
`ifdef MEM_WB_FWD_EN
        chk("t5_fwd", 32'({fwd_valid, fwd_addr, fwd_data}), 32'({1'b1, 3'd3, 16'h7777}));
`else
        chk("t5_fwd", 32'({fwd_valid, fwd_addr, fwd_data}), 32'(0));
`endif
        repeat (3) idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 500; i++)
            cycle(1'($urandom_range(0, 3) != 0), 51'({$urandom(), $urandom()}), 3'($urandom()),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), acc);
        repeat (4) idle(1'b1);

        // Mid-transfer reset with a full queue.
        cycle(1'b1, {3'b001, 16'h0, 16'hDEAD, 16'h0}, 3'd1, 1'b0, 1'b0, acc);
        cycle(1'b1, {3'b001, 16'h0, 16'hFACE, 16'h0}, 3'd2, 1'b0, 1'b0, acc);
        do_reset();
        idle(1'b1);
        chk("t6_wb_en", 32'(wb_en), 32'(0));

        // Counter wrap.
        for (int i = 0; i < 65535; i++)
            cycle(1'b1, {3'b001, 16'h0, 16'($urandom()), 16'h0}, 3'($urandom()), 1'b1, 1'b0, acc);
        idle(1'b1);
        chk("t7_retired_ffff", 32'(retired), 32'(16'hFFFF));
        cycle(1'b1, {3'b001, 16'h0, 16'h0F0F, 16'h0}, 3'd4, 1'b1, 1'b0, acc);
        idle(1'b1);
        chk("t7_retired_wrap", 32'(retired), 32'(0));

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
